// File: rtl/crc_feeder_pkg.sv
// Shared types and constants for the TinyQV CRC32 peripheral feeder.
package crc_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_EN,
        ST_WR_CFG,
        ST_WAIT_BYTE,
        ST_WR_BYTE,
        ST_RD_REQ,
        ST_DONE
    } feeder_state_t;

    // Peripheral register map.
    localparam logic [5:0] REG_ENABLE = 6'h00;
    localparam logic [5:0] REG_CONFIG = 6'h04;
    localparam logic [5:0] REG_DATA   = 6'h08;
    localparam logic [5:0] REG_RESULT = 6'h0C;

    // Active-low access-size encodings shared by bus_write_n and bus_read_n.
    typedef enum logic [1:0] {
        BUS_B    = 2'b00,
        BUS_H    = 2'b01,
        BUS_W    = 2'b10,
        BUS_NONE = 2'b11
    } bus_size_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/crc_feeder_wdog.sv
// Read-response watchdog for tqv_crc_feeder: counts enabled cycles after a load,
// flags expiry on the LIMIT-th consecutive enabled cycle.
module crc_feeder_wdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count_en,
    output logic expired
);

    logic [7:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (count_en && !expired) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expired = count_en && (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/tqv_crc_feeder.sv
// Bus initiator for the TinyQV CRC32 peripheral: programs it, streams bytes in, reads the CRC back.
// Optional result-read watchdog and timeout_err flag enabled by defining CRC_FEEDER_TIMEOUT_EN.
module tqv_crc_feeder
    import crc_feeder_pkg::*;
#(
    parameter logic [5:0] ADDR_ENABLE = REG_ENABLE,
    parameter logic [5:0] ADDR_CONFIG = REG_CONFIG,
    parameter logic [5:0] ADDR_DATA   = REG_DATA,
    parameter logic [5:0] ADDR_RESULT = REG_RESULT
`ifdef CRC_FEEDER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  cfg_mode,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [5:0]  bus_addr,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_write_n,
    output logic [1:0]  bus_read_n,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic [31:0] res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] byte_count,
    output logic        busy,
    output logic        timeout_err
);

    feeder_state_t state_q, state_d;
    logic [7:0]    cfg_q, cfg_d;
    logic          last_q, last_d;
    logic [5:0]    addr_d;
    logic [31:0]   wdata_d;
    logic [1:0]    write_n_d, read_n_d;
    logic          s_ready_d, res_valid_d, busy_d;
    logic [31:0]   res_data_d;
    logic [15:0]   count_d;

`ifdef CRC_FEEDER_TIMEOUT_EN
    logic terr_q, terr_d, wd_expired;

    crc_feeder_wdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q != ST_RD_REQ),
        .count_en (state_q == ST_RD_REQ && !bus_ready),
        .expired  (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            terr_q <= 1'b0;
        end else begin
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Outputs are registered from the state being entered, so each bus cycle
    // appears exactly while the FSM sits in the matching state.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        last_d      = last_q;
        addr_d      = bus_addr;
        wdata_d     = bus_wdata;
        write_n_d   = BUS_NONE;
        read_n_d    = BUS_NONE;
        s_ready_d   = 1'b0;
        res_valid_d = res_valid;
        res_data_d  = res_data;
        count_d     = byte_count;
`ifdef CRC_FEEDER_TIMEOUT_EN
        terr_d      = terr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_d     = cfg_mode;
                    count_d   = '0;
`ifdef CRC_FEEDER_TIMEOUT_EN
                    terr_d    = 1'b0;
`endif
                    state_d   = ST_WR_EN;
                    write_n_d = BUS_B;
                    addr_d    = ADDR_ENABLE;
                    wdata_d   = 32'h0000_0001;
                end
            end
            ST_WR_EN: begin
                state_d   = ST_WR_CFG;
                write_n_d = BUS_B;
                addr_d    = ADDR_CONFIG;
                wdata_d   = {24'h0, cfg_q};
            end
            ST_WR_CFG: begin
                state_d   = ST_WAIT_BYTE;
                s_ready_d = 1'b1;
            end
            ST_WAIT_BYTE: begin
                if (s_valid && s_ready) begin
                    state_d   = ST_WR_BYTE;
                    last_d    = s_last;
                    write_n_d = BUS_B;
                    addr_d    = ADDR_DATA;
                    wdata_d   = {24'h0, s_data};
                end else begin
                    s_ready_d = 1'b1;
                end
            end
            ST_WR_BYTE: begin
                count_d = sat_inc16(byte_count);
                if (last_q) begin
                    state_d  = ST_RD_REQ;
                    read_n_d = BUS_W;
                    addr_d   = ADDR_RESULT;
                end else begin
                    state_d   = ST_WAIT_BYTE;
                    s_ready_d = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (bus_ready) begin
                    res_data_d  = bus_rdata;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
`ifdef CRC_FEEDER_TIMEOUT_EN
                end else if (wd_expired) begin
                    res_data_d  = '1;
                    res_valid_d = 1'b1;
                    terr_d      = 1'b1;
                    state_d     = ST_DONE;
`endif
                end else begin
                    read_n_d = BUS_W;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            last_q      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_write_n <= BUS_NONE;
            bus_read_n  <= BUS_NONE;
            s_ready     <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            byte_count  <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            last_q      <= last_d;
            bus_addr    <= addr_d;
            bus_wdata   <= wdata_d;
            bus_write_n <= write_n_d;
            bus_read_n  <= read_n_d;
            s_ready     <= s_ready_d;
            res_valid   <= res_valid_d;
            res_data    <= res_data_d;
            byte_count  <= count_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_tqv_crc_feeder.sv
// Self-checking bench for tqv_crc_feeder: transaction-level bus/result model plus directed jobs.
module tb_tqv_crc_feeder;

    localparam int unsigned TMO   = 16;
    localparam logic [5:0]  A_EN  = 6'h00;
    localparam logic [5:0]  A_CFG = 6'h04;
    localparam logic [5:0]  A_DAT = 6'h08;
    localparam logic [5:0]  A_RES = 6'h0C;

    logic        clk, rst_n, start;
    logic [7:0]  cfg_mode, s_data;
    logic        s_valid, s_last, s_ready;
    logic [5:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic [1:0]  bus_write_n, bus_read_n;
    logic        bus_ready;
    logic [31:0] res_data;
    logic        res_valid, res_ready;
    logic [15:0] byte_count;
    logic        busy, timeout_err;

    logic        resp_hang;
    int unsigned resp_delay;
    logic [31:0] resp_value;
    int unsigned rd_wait;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        bit          last;
    } wr_t;

    wr_t         exp_q[$];
    bit          job_active, read_pending, res_pending, terr_m;
    logic [31:0] res_exp;
    int unsigned count_m, rd_cycles, last_rd_len, n_wr, n_rd;
    logic [7:0]  job_bytes [0:15];

    tqv_crc_feeder #(
        .ADDR_ENABLE(6'h00)
`ifdef CRC_FEEDER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_mode   (cfg_mode),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_write_n(bus_write_n),
        .bus_read_n (bus_read_n),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .byte_count (byte_count),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Peripheral responder: ready (combinationally) after resp_delay wait cycles.
    assign bus_rdata = resp_value;
    assign bus_ready = (bus_read_n == 2'b10) && !resp_hang && (rd_wait >= resp_delay);
    always @(posedge clk) begin
        if (bus_read_n == 2'b10 && !bus_ready) rd_wait <= rd_wait + 1;
        else                                   rd_wait <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        logic wr, rd, hs;
        wr_t  h;
        if (!rst_n) begin
            chk("rst_write_n", bus_write_n, 2'b11);
            chk("rst_read_n", bus_read_n, 2'b11);
            chk("rst_busy", busy, 1'b0);
            chk("rst_s_ready", s_ready, 1'b0);
            chk("rst_res_valid", res_valid, 1'b0);
            chk("rst_byte_count", byte_count, 16'd0);
            exp_q.delete();
            job_active = 0; read_pending = 0; res_pending = 0; terr_m = 0;
            count_m = 0; rd_cycles = 0;
        end else begin
            wr = (bus_write_n != 2'b11);
            rd = (bus_read_n != 2'b11);
            hs = res_valid && res_ready;
            if (wr && bus_addr == A_EN) begin
                count_m = 0; terr_m = 0; job_active = 1;
            end
            chk("busy", busy, job_active);
            chk("s_ready", s_ready,
                job_active && !wr && exp_q.size() > 0 && exp_q[0].addr == A_DAT);
            chk("byte_count", byte_count, count_m);
            chk("timeout_err", timeout_err, terr_m);
            chk("res_valid", res_valid, res_pending);
            if (res_pending) chk("res_data", res_data, res_exp);
            if (hs && res_pending) begin
                res_pending = 0; job_active = 0;
            end
            chk("rd_active", rd, read_pending);
            if (rd) begin
                chk("rd_size", bus_read_n, 2'b10);
                chk("rd_addr", bus_addr, A_RES);
                if (rd_cycles == 0) n_rd++;
                rd_cycles++;
                if (bus_ready) begin
                    res_pending = 1; res_exp = resp_value; read_pending = 0;
                    last_rd_len = rd_cycles; rd_cycles = 0;
`ifdef CRC_FEEDER_TIMEOUT_EN
                end else if (rd_cycles == TMO) begin
                    res_pending = 1; res_exp = 32'hFFFF_FFFF; terr_m = 1; read_pending = 0;
                    last_rd_len = rd_cycles; rd_cycles = 0;
`endif
                end
            end
            if (wr) begin
                n_wr++;
                chk("wr_size", bus_write_n, 2'b00);
                chk("wr_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    h = exp_q.pop_front();
                    chk("wr_addr", bus_addr, h.addr);
                    chk("wr_data", bus_wdata, h.data);
                    if (h.addr == A_DAT) count_m++;
                    if (h.last) read_pending = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] cfg);
        start = 1'b1; cfg_mode = cfg;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_job(input logic [7:0] cfg, input int unsigned n);
        exp_q.push_back('{addr: A_EN, data: 32'h1, last: 1'b0});
        exp_q.push_back('{addr: A_CFG, data: {24'h0, cfg}, last: 1'b0});
        for (int unsigned i = 0; i < n; i++)
            exp_q.push_back('{addr: A_DAT, data: {24'h0, job_bytes[i]}, last: (i == n - 1)});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit got;
        got = 0;
        s_data = b; s_last = last; s_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (s_ready) begin
                got = 1;
                break;
            end
        end
        chk("s_ready_wait", got, 1'b1);
        tick();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic feed(input int unsigned from, input int unsigned n, input int unsigned last_idx,
                        input int unsigned gap);
        for (int unsigned i = from; i < n; i++) begin
            send_byte(job_bytes[i], i == last_idx);
            repeat (gap) tick();
        end
    endtask

    task automatic wait_res(input int unsigned max);
        for (int unsigned k = 0; k < max; k++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        chk("res_valid_wait", res_valid, 1'b1);
    endtask

    task automatic handshake(input int unsigned hold, input bit with_start);
        repeat (hold) tick();
        tick();
        res_ready = 1'b1;
        if (with_start) begin
            start = 1'b1; cfg_mode = 8'h77;
        end
        tick();
        res_ready = 1'b0; start = 1'b0;
    endtask

    task automatic reset_mid();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_write_n", bus_write_n, 2'b11);
        chk("mid_rst_read_n", bus_read_n, 2'b11);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_byte_count", byte_count, 16'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned wr0, rd0;
        bit seen;
        start = 0; cfg_mode = 0; s_data = 0; s_valid = 0; s_last = 0; res_ready = 0;
        resp_hang = 0; resp_delay = 0; resp_value = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("init_write_n", bus_write_n, 2'b11);
        chk("init_read_n", bus_read_n, 2'b11);
        chk("init_addr", bus_addr, 6'h00);
        chk("init_wdata", bus_wdata, 32'h0);
        chk("init_res_data", res_data, 32'h0);
        chk("init_busy", busy, 1'b0);
        chk("init_timeout_err", timeout_err, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Golden "123456789"
        for (int unsigned i = 0; i < 9; i++) job_bytes[i] = 8'h31 + 8'(i);
        resp_value = 32'hCBF4_3926; resp_delay = 0;
        wr0 = n_wr; rd0 = n_rd;
        expect_job(8'h01, 9);
        pulse_start(8'h01);
        feed(0, 9, 8, 0);
        wait_res(40);
        chk("golden_res_data", res_data, 32'hCBF4_3926);
        chk("golden_byte_count", byte_count, 16'd9);
        handshake(0, 1'b0);
        chk("golden_writes", n_wr - wr0, 11);
        chk("golden_reads", n_rd - rd0, 1);
        chk("golden_rd_len", last_rd_len, 1);

        // Stalled stream, busy start ignored, slow result read, stalled result consumer
        for (int unsigned i = 0; i < 4; i++) job_bytes[i] = 8'h10 + 8'(i);
        resp_value = 32'h0BAD_F00D; resp_delay = 2;
        repeat (2) tick();
        wr0 = n_wr; rd0 = n_rd;
        expect_job(8'hA5, 4);
        pulse_start(8'hA5);
        send_byte(job_bytes[0], 1'b0);
        tick();
        pulse_start(8'h55);
        repeat (2) tick();
        feed(1, 4, 3, 3);
        wait_res(40);
        repeat (5) tick();
        chk("stall_res_valid_held", res_valid, 1'b1);
        chk("stall_res_data_held", res_data, 32'h0BAD_F00D);
        chk("stall_byte_count", byte_count, 16'd4);
        handshake(0, 1'b1);
        repeat (3) tick();
        chk("stall_idle_busy", busy, 1'b0);
        chk("stall_writes", n_wr - wr0, 6);
        chk("stall_reads", n_rd - rd0, 1);
        chk("stall_rd_len", last_rd_len, 3);

        // Result read never answered
        job_bytes[0] = 8'hAB;
        resp_hang = 1'b1; resp_delay = 0;
        expect_job(8'h01, 1);
        pulse_start(8'h01);
        feed(0, 1, 0, 0);
`ifdef CRC_FEEDER_TIMEOUT_EN
        wait_res(60);
        chk("tmo_res_data", res_data, 32'hFFFF_FFFF);
        chk("tmo_err", timeout_err, 1'b1);
        tick();
        chk("tmo_rd_len", last_rd_len, TMO);
        handshake(0, 1'b0);
        resp_hang = 1'b0;
`else
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_read_n == 2'b10) begin
                seen = 1;
                break;
            end
        end
        chk("hang_read_started", seen, 1'b1);
        repeat (40) tick();
        chk("hang_read_held", bus_read_n, 2'b10);
        chk("hang_no_result", res_valid, 1'b0);
        chk("hang_busy", busy, 1'b1);
        reset_mid();
        resp_hang = 1'b0;
        tick();
`endif

        // Reset after three bytes, then a fresh job replays the setup writes
        for (int unsigned i = 0; i < 9; i++) job_bytes[i] = 8'h31 + 8'(i);
        expect_job(8'h02, 9);
        pulse_start(8'h02);
        feed(0, 3, 8, 0);
        reset_mid();
        tick();
        resp_value = 32'h1234_5678; resp_delay = 0;
        expect_job(8'h03, 5);
        pulse_start(8'h03);
        feed(0, 5, 4, 1);
        wait_res(40);
        chk("replay_res_data", res_data, 32'h1234_5678);
        chk("replay_byte_count", byte_count, 16'd5);
        chk("replay_timeout_err", timeout_err, 1'b0);
        handshake(1, 1'b0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
